mem_responder: RTL

Memory-side responder for the core's load/store interface: accepts one byte/half/word request at a time over a valid/ready handshake, performs the read or byte-enabled write on an internal word-organised array, and returns the result over a second valid/ready handshake. It sits on the opposite end of the processor's memory port. It replaces the read-only, write-disabled memory path so that stores and sub-word loads become possible, with optional wait states to model slower memory.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Load/store memory responder: one request at a time, byte-enabled word array, optional wait states.
// Define MEM_RESPONDER_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of rounding them down.
module mem_responder #(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [7:0]  cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem [MEM_SIZE];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             err_d;
  logic [3:0]       be_d;
  logic [31:0]      wword_d;
  logic [31:0]      rword;
  logic [31:0]      rshift;
  logic [31:0]      rdata_d;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    idx     = addr_q[IDX_W+1:2];
    lane    = 2'b00;
    be_d    = 4'b0000;
    wword_d = wdata_q;
    err_d   = (addr_q[31:2] >= 30'(MEM_SIZE)) || (size_q == 2'b11);
    case (size_q)
      2'b00: begin
        lane    = addr_q[1:0];
        be_d    = 4'b0001 << addr_q[1:0];
        wword_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane    = {addr_q[1], 1'b0};
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{wdata_q[15:0]}};
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
        err_d   = err_d || addr_q[0];
`endif
      end
      2'b10: begin
        be_d    = 4'b1111;
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
        err_d   = err_d || (addr_q[1:0] != 2'b00);
`endif
      end
      default: begin
        be_d    = 4'b0000;
      end
    endcase

    rword  = mem[idx];
    rshift = rword >> {lane, 3'b000};
    case (size_q)
      2'b00:   rdata_d = unsigned_q ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   rdata_d = unsigned_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      2'b10:   rdata_d = rword;
      default: rdata_d = '0;
    endcase
    if (err_d || we_q) rdata_d = '0;
  end

  // Array has no reset; a reset landing on the ACCESS edge must still block the write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_ACCESS && we_q && !err_d) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_d[i]) mem[idx][8*i +: 8] <= wword_d[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= 8'(WAIT_CYCLES - 1);
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 8'd0) state_q <= ST_ACCESS;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        ST_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_d;
          rsp_err_q   <= err_d;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
